// File: rtl/cva6_i2c_xfer_seq_if.sv
// rtl/cva6_i2c_xfer_seq_if.sv - request/response and APB signal bundle for the I2C transfer sequencer
// master modport: sequencer side (accepts requests, returns responses, masters the APB bus)
// slave modport : environment side (issues requests, implements the APB I2C peripheral)
interface cva6_i2c_xfer_seq_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_rnw_i;
  logic [6:0]                req_dev_i;
  logic [7:0]                req_reg_i;
  logic [7:0]                req_wdata_i;
  logic                      rsp_valid_o;
  logic [1:0]                rsp_err_o;
  logic [7:0]                rsp_rdata_o;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;

  modport master (
    input  req_valid_i, req_rnw_i, req_dev_i, req_reg_i, req_wdata_i, PRDATA, PREADY,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid_i, req_rnw_i, req_dev_i, req_reg_i, req_wdata_i, PRDATA, PREADY,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/cva6_i2c_xfer_seq.sv
// rtl/cva6_i2c_xfer_seq.sv - APB master turning one register request into a full I2C byte sequence
// HCLK   : clock
// HRESET : synchronous reset, active-high
// bus    : request/response handshake plus APB master signals (master modport)
module cva6_i2c_xfer_seq #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter logic [15:0] PRESCALE       = 16'h0063,
  parameter int          TIMEOUT_POLLS  = 1024
) (
  input logic                 HCLK,
  input logic                 HRESET,
  cva6_i2c_xfer_seq_if.master bus
);

  localparam int PW = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [PW-1:0] LAST_POLL = PW'(TIMEOUT_POLLS - 1);

  // peripheral register word offsets (byte address = offset << 2)
  localparam logic [3:0] OFF_PRE    = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h1;
  localparam logic [3:0] OFF_RX     = 4'h2;
  localparam logic [3:0] OFF_STATUS = 4'h3;
  localparam logic [3:0] OFF_TX     = 4'h4;
  localparam logic [3:0] OFF_CMD    = 4'h5;

  localparam logic [7:0] CMD_STA_WR    = 8'h90;
  localparam logic [7:0] CMD_WR        = 8'h10;
  localparam logic [7:0] CMD_WR_STO    = 8'h50;
  localparam logic [7:0] CMD_RD_NAK_ST = 8'h68;
  localparam logic [7:0] CMD_STO       = 8'h40;
  localparam logic [7:0] CMD_IACK      = 8'h01;

  typedef enum logic [3:0] {
    S_INIT_PRE, S_INIT_CTRL, S_IDLE, S_WR_TX, S_WR_CMD, S_POLL, S_CLR_IRQ,
    S_RD_RX, S_STOP_CMD, S_STOP_POLL, S_STOP_IACK, S_RESP
  } state_t;

  state_t        state_q, state_n;
  logic          psel_q, psel_n;
  logic          penable_q, penable_n;
  logic [1:0]    step_q, step_n;
  logic          rnw_q, rnw_n;
  logic [6:0]    dev_q, dev_n;
  logic [7:0]    reg_q, reg_n;
  logic [7:0]    wdata_q, wdata_n;
  logic [1:0]    err_q, err_n;
  logic [7:0]    status_q, status_n;
  logic [7:0]    rdata_q, rdata_n;
  logic [PW-1:0] polls_q, polls_n;

  logic       xfer_write;
  logic [3:0] xfer_off;
  logic [15:0] xfer_data;
  logic [7:0] tx_byte;
  logic [7:0] cmd_byte;
  logic       final_step;
  logic       unused_prdata_hi;

  assign unused_prdata_hi = ^bus.PRDATA[31:8];

  // IDLE and RESP are the only states that do not own an APB transfer
  function automatic logic is_apb(input state_t s);
    return !(s == S_IDLE || s == S_RESP);
  endfunction

  // byte-step table: read uses a repeated START with the R bit, then a receive with NACK+STOP
  always_comb begin
    tx_byte  = 8'h00;
    cmd_byte = CMD_RD_NAK_ST;
    case (step_q)
      2'd0: begin tx_byte = {dev_q, 1'b0}; cmd_byte = CMD_STA_WR; end
      2'd1: begin tx_byte = reg_q;         cmd_byte = CMD_WR;     end
      2'd2: begin
        tx_byte  = rnw_q ? {dev_q, 1'b1} : wdata_q;
        cmd_byte = rnw_q ? CMD_STA_WR : CMD_WR_STO;
      end
      default: ;
    endcase
  end

  assign final_step = (step_q == (rnw_q ? 2'd3 : 2'd2));

  // the transfer a state performs; held stable because state only moves on completion
  always_comb begin
    xfer_write = 1'b1;
    xfer_off   = OFF_CMD;
    xfer_data  = 16'h0000;
    case (state_q)
      S_INIT_PRE:              begin xfer_off = OFF_PRE;  xfer_data = PRESCALE; end
      S_INIT_CTRL:             begin xfer_off = OFF_CTRL; xfer_data = 16'h0080; end
      S_WR_TX:                 begin xfer_off = OFF_TX;   xfer_data = {8'h00, tx_byte}; end
      S_WR_CMD:                xfer_data = {8'h00, cmd_byte};
      S_POLL, S_STOP_POLL:     begin xfer_write = 1'b0; xfer_off = OFF_STATUS; end
      S_RD_RX:                 begin xfer_write = 1'b0; xfer_off = OFF_RX; end
      S_CLR_IRQ, S_STOP_IACK:  xfer_data = {8'h00, CMD_IACK};
      S_STOP_CMD:              xfer_data = {8'h00, CMD_STO};
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state_q;
    psel_n    = psel_q;
    penable_n = penable_q;
    step_n    = step_q;
    rnw_n     = rnw_q;
    dev_n     = dev_q;
    reg_n     = reg_q;
    wdata_n   = wdata_q;
    err_n     = err_q;
    status_n  = status_q;
    rdata_n   = rdata_q;
    polls_n   = polls_q;

    if (psel_q && penable_q && bus.PREADY) begin
      case (state_q)
        S_INIT_PRE:  state_n = S_INIT_CTRL;
        S_INIT_CTRL: state_n = S_IDLE;
        S_WR_TX:     state_n = S_WR_CMD;
        S_WR_CMD: begin
          state_n = S_POLL;
          polls_n = '0;
        end
        S_POLL: begin
          status_n = bus.PRDATA[7:0];
          if (bus.PRDATA[0]) begin
            state_n = S_CLR_IRQ;
          end else if (polls_q == LAST_POLL) begin
            err_n   = 2'b11;
            state_n = S_STOP_CMD;
          end else begin
            polls_n = polls_q + PW'(1);
          end
        end
        S_CLR_IRQ: begin
          if (status_q[5]) begin
            // arbitration lost: the bus is no longer ours, so no STOP
            err_n   = 2'b10;
            state_n = S_RESP;
          end else if (status_q[7] && !(rnw_q && final_step)) begin
            // RXACK on the read data byte is our own NACK, not an error
            err_n   = 2'b01;
            state_n = S_STOP_CMD;
          end else if (final_step) begin
            state_n = rnw_q ? S_RD_RX : S_RESP;
          end else begin
            step_n  = step_q + 2'd1;
            // the read data byte is a receive; there is nothing to load into TX
            state_n = (step_q == 2'd2) ? S_WR_CMD : S_WR_TX;
          end
        end
        S_RD_RX: begin
          rdata_n = bus.PRDATA[7:0];
          state_n = S_RESP;
        end
        S_STOP_CMD: begin
          state_n = S_STOP_POLL;
          polls_n = '0;
        end
        S_STOP_POLL: begin
          if (bus.PRDATA[0]) begin
            state_n = S_STOP_IACK;
          end else if (polls_q == LAST_POLL) begin
            state_n = S_RESP;
          end else begin
            polls_n = polls_q + PW'(1);
          end
        end
        S_STOP_IACK: state_n = S_RESP;
        default:     state_n = S_IDLE;
      endcase
      // chain straight into the next SETUP phase when the next state also transfers
      psel_n    = is_apb(state_n);
      penable_n = 1'b0;
    end else if (psel_q) begin
      penable_n = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            rnw_n   = bus.req_rnw_i;
            dev_n   = bus.req_dev_i;
            reg_n   = bus.req_reg_i;
            wdata_n = bus.req_wdata_i;
            step_n  = 2'd0;
            err_n   = 2'b00;
            rdata_n = 8'h00;
            state_n = S_WR_TX;
          end
        end
        S_RESP:  state_n = S_IDLE;
        default: psel_n  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_INIT_PRE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      step_q    <= 2'd0;
      rnw_q     <= 1'b0;
      dev_q     <= 7'h00;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      err_q     <= 2'b00;
      status_q  <= 8'h00;
      rdata_q   <= 8'h00;
      polls_q   <= '0;
    end else begin
      state_q   <= state_n;
      psel_q    <= psel_n;
      penable_q <= penable_n;
      step_q    <= step_n;
      rnw_q     <= rnw_n;
      dev_q     <= dev_n;
      reg_q     <= reg_n;
      wdata_q   <= wdata_n;
      err_q     <= err_n;
      status_q  <= status_n;
      rdata_q   <= rdata_n;
      polls_q   <= polls_n;
    end
  end

  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = psel_q & xfer_write;
  assign bus.PADDR       = psel_q ? {{(APB_ADDR_WIDTH-6){1'b0}}, xfer_off, 2'b00} : '0;
  assign bus.PWDATA      = (psel_q && xfer_write) ? {16'h0000, xfer_data} : 32'h0;
  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.rsp_valid_o = (state_q == S_RESP);
  assign bus.rsp_err_o   = (state_q == S_RESP) ? err_q : 2'b00;
  assign bus.rsp_rdata_o = (state_q == S_RESP) ? rdata_q : 8'h00;

endmodule

// File: tb/tb_cva6_i2c_xfer_seq.sv
// tb/tb_cva6_i2c_xfer_seq.sv - scoreboard bench for the I2C transfer sequencer with a behavioural peripheral
module tb_cva6_i2c_xfer_seq;
  localparam int          TO    = 8;
  localparam logic [15:0] PRESC = 16'h0063;
  localparam logic [11:0] A_PRE = 12'h000, A_CTRL = 12'h004, A_RX = 12'h008;
  localparam logic [11:0] A_STATUS = 12'h00C, A_TX = 12'h010, A_CMD = 12'h014;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  cva6_i2c_xfer_seq_if #(.APB_ADDR_WIDTH(12)) bus ();

  cva6_i2c_xfer_seq #(.APB_ADDR_WIDTH(12), .PRESCALE(PRESC), .TIMEOUT_POLLS(TO)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .bus(bus.master)
  );

  typedef struct packed { logic w; logic [11:0] a; logic [31:0] d; } apb_t;
  typedef struct packed { logic [1:0] err; logic [7:0] rd; } rsp_t;
  apb_t exp_apb[$];
  rsp_t exp_rsp[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cyc_done = 0;

  // slave behaviour for the current transaction
  int lat[4];
  int nack_s, al_s, noif_s, stop_lat, wait_cfg;
  logic [7:0] rd_byte;
  int txn_id = 0;

  // peripheral internal state
  int pstep = -1, rcount = 0, wcnt = 0, seen_id = 0;
  bit in_stop = 0, ifl = 0, fin = 0, prev_pend = 0;
  logic prev_w;
  logic [11:0] prev_a;
  logic [31:0] prev_d;
  apb_t pe;
  logic [7:0] st;
  rsp_t rr;
  bit rsp_prev = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void push_w(logic [11:0] a, logic [31:0] d);
    apb_t e;
    e.w = 1'b1; e.a = a; e.d = d;
    exp_apb.push_back(e);
  endfunction

  function automatic void push_r(logic [11:0] a);
    apb_t e;
    e.w = 1'b0; e.a = a; e.d = 32'h0;
    exp_apb.push_back(e);
  endfunction

  // behavioural APB I2C peripheral plus bus-protocol checks, evaluated mid-cycle
  always @(negedge HCLK) begin
    if (HRESET) begin
      pstep = -1; rcount = 0; in_stop = 0; ifl = 0; wcnt = 0; prev_pend = 0;
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'h0;
    end else begin
      fin = 0;
      if (prev_pend)
        chk("apb_stable", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
            {1'b1, 1'b1, prev_w, prev_a, prev_d});
      if (bus.PSEL && bus.PENABLE) begin
        if (wcnt < wait_cfg) begin
          bus.PREADY = 1'b0;
          wcnt++;
        end else begin
          bus.PREADY = 1'b1;
          wcnt = 0;
          fin = 1;
        end
      end else begin
        bus.PREADY = (wait_cfg == 0);
      end
      if (fin) begin
        cyc_done = cyc + 1;
        if (seen_id != txn_id) begin
          seen_id = txn_id;
          pstep = -1;
        end
        chk("apb_expected", 64'(exp_apb.size() != 0), 64'd1);
        if (exp_apb.size() != 0) begin
          pe = exp_apb.pop_front();
          if (pe.w) chk("apb_xfer", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {pe.w, pe.a, pe.d});
          else      chk("apb_xfer", {bus.PWRITE, bus.PADDR}, {pe.w, pe.a});
        end
        bus.PRDATA = $urandom();
        if (bus.PWRITE && bus.PADDR == A_CMD) begin
          if (bus.PWDATA[7:0] == 8'h01) ifl = 0;
          else if (bus.PWDATA[7:0] == 8'h40) begin in_stop = 1; rcount = 0; ifl = 0; end
          else begin pstep++; in_stop = 0; rcount = 0; ifl = 0; end
        end else if (!bus.PWRITE && bus.PADDR == A_STATUS) begin
          rcount++;
          if (in_stop) begin
            if (rcount >= stop_lat) ifl = 1;
            st = {6'b0, !ifl, ifl};
          end else begin
            if (pstep >= 0 && pstep < 4 && pstep != noif_s && rcount >= lat[pstep]) ifl = 1;
            st = {pstep == nack_s, 1'($urandom), pstep == al_s, 3'b000, !ifl, ifl};
          end
          bus.PRDATA[7:0] = st;
        end else if (!bus.PWRITE && bus.PADDR == A_RX) begin
          bus.PRDATA[7:0] = rd_byte;
        end
      end
      prev_pend = bus.PSEL && !fin;
      prev_w = bus.PWRITE;
      prev_a = bus.PADDR;
      prev_d = bus.PWDATA;
    end
  end

  // response monitor
  always @(negedge HCLK) begin
    if (HRESET) begin
      rsp_prev = 0;
    end else begin
      if (rsp_prev) chk("rsp_one_cycle_then_ready", {bus.rsp_valid_o, bus.req_ready_o}, {1'b0, 1'b1});
      rsp_prev = bus.rsp_valid_o;
      if (bus.rsp_valid_o) begin
        chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
        chk("ready_low_during_rsp", bus.req_ready_o, 0);
        if (exp_rsp.size() != 0) begin
          rr = exp_rsp.pop_front();
          chk("rsp_err_rdata", {bus.rsp_err_o, bus.rsp_rdata_o}, {rr.err, rr.rd});
        end
      end
    end
  end

  task automatic set_clean();
    nack_s = -1; al_s = -1; noif_s = -1; stop_lat = 2; wait_cfg = 0; rd_byte = 8'h00;
    for (int i = 0; i < 4; i++) lat[i] = 1;
  endtask

  // expected APB trace and response derived from the byte-step rules
  task automatic build(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    int steps;
    logic [1:0] err;
    bit stop;
    logic [7:0] tx, cmd;
    rsp_t r;
    steps = rnw ? 4 : 3;
    err = 2'b00;
    stop = 0;
    for (int s = 0; s < steps; s++) begin
      case (s)
        0: begin tx = {dev, 1'b0}; cmd = 8'h90; end
        1: begin tx = rg; cmd = 8'h10; end
        2: begin tx = rnw ? {dev, 1'b1} : wd; cmd = rnw ? 8'h90 : 8'h50; end
        default: begin tx = 8'h00; cmd = 8'h68; end
      endcase
      if (s != 3) push_w(A_TX, {24'h0, tx});
      push_w(A_CMD, {24'h0, cmd});
      if (s == noif_s) begin
        repeat (TO) push_r(A_STATUS);
        err = 2'b11; stop = 1;
        break;
      end
      repeat (lat[s]) push_r(A_STATUS);
      push_w(A_CMD, 32'h1);
      if (s == al_s) begin err = 2'b10; break; end
      if (s == nack_s && s != 3) begin err = 2'b01; stop = 1; break; end
      if (s == 3) push_r(A_RX);
    end
    if (stop) begin
      push_w(A_CMD, 32'h40);
      repeat (stop_lat) push_r(A_STATUS);
      push_w(A_CMD, 32'h1);
    end
    r.err = err;
    r.rd = (err == 2'b00 && rnw) ? rd_byte : 8'h00;
    exp_rsp.push_back(r);
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge HCLK);
    while (!bus.req_ready_o && n < 500) begin
      @(negedge HCLK);
      n++;
    end
    chk(nm, bus.req_ready_o, 1);
  endtask

  task automatic send(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    txn_id++;
    wait_ready("ready_before_req");
    bus.req_valid_i = 1'b1;
    bus.req_rnw_i = rnw;
    bus.req_dev_i = dev;
    bus.req_reg_i = rg;
    bus.req_wdata_i = wd;
    @(posedge HCLK);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_rnw_i = 1'($urandom);
    bus.req_dev_i = 7'($urandom);
    bus.req_reg_i = 8'($urandom);
    bus.req_wdata_i = 8'($urandom);
  endtask

  task automatic run(input bit rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    int n;
    build(rnw, dev, rg, wd);
    send(rnw, dev, rg, wd);
    n = 0;
    @(negedge HCLK);
    while (!(exp_rsp.size() == 0 && bus.req_ready_o) && n < 3000) begin
      @(negedge HCLK);
      n++;
    end
    chk("txn_complete", 64'(exp_rsp.size() == 0 && bus.req_ready_o), 64'd1);
    chk("apb_trace_consumed", exp_apb.size(), 0);
  endtask

  initial begin
    bit rnw;
    int fs, kind, n;
    bus.req_valid_i = 1'b0;
    bus.req_rnw_i = 1'b0;
    bus.req_dev_i = 7'h00;
    bus.req_reg_i = 8'h00;
    bus.req_wdata_i = 8'h00;
    set_clean();
    push_w(A_PRE, {16'h0, PRESC});
    push_w(A_CTRL, 32'h80);
    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_values", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.req_ready_o,
                         bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o}, 64'h0);
    HRESET = 1'b0;
    wait_ready("ready_after_init");
    chk("ready_cycle_after_ctrl", cyc, cyc_done);
    chk("init_trace_consumed", exp_apb.size(), 0);

    set_clean();
    lat[0] = 2; lat[1] = 1; lat[2] = 3;
    run(1'b0, 7'h50, 8'h12, 8'hA5);

    set_clean();
    lat[0] = 1; lat[1] = 2; lat[2] = 1; lat[3] = 2; rd_byte = 8'h5A;
    run(1'b1, 7'h50, 8'h34, 8'h00);

    set_clean();
    nack_s = 0;
    run(1'b0, 7'h50, 8'h12, 8'hA5);

    set_clean();
    al_s = 0; rd_byte = 8'h77;
    run(1'b1, 7'h21, 8'h05, 8'h00);

    set_clean();
    noif_s = 0;
    run(1'b0, 7'h3C, 8'h44, 8'h99);

    set_clean();
    nack_s = 3; rd_byte = 8'hC3;
    run(1'b1, 7'h11, 8'hF0, 8'h00);

    // wait states plus reset in the middle of a STATUS poll
    set_clean();
    wait_cfg = 5;
    for (int i = 0; i < 4; i++) lat[i] = 4;
    build(1'b0, 7'h50, 8'h12, 8'hA5);
    send(1'b0, 7'h50, 8'h12, 8'hA5);
    n = 0;
    @(posedge HCLK);
    while (!(pstep == 1 && rcount >= 2 && !in_stop) && n < 1000) begin
      @(posedge HCLK);
      n++;
    end
    chk("reached_mid_poll", 64'(pstep == 1 && rcount >= 2), 64'd1);
    #1;
    HRESET = 1'b1;
    exp_apb.delete();
    exp_rsp.delete();
    push_w(A_PRE, {16'h0, PRESC});
    push_w(A_CTRL, 32'h80);
    @(posedge HCLK);
    #1;
    chk("psel_dropped_after_reset", {bus.PSEL, bus.PENABLE, bus.rsp_valid_o}, 0);
    HRESET = 1'b0;
    wait_ready("ready_after_reinit");
    chk("reinit_trace_consumed", exp_apb.size(), 0);

    for (int t = 0; t < 40; t++) begin
      set_clean();
      wait_cfg = $urandom_range(0, 2);
      stop_lat = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) lat[i] = $urandom_range(1, 4);
      rd_byte = 8'($urandom);
      rnw = 1'($urandom);
      fs = $urandom_range(0, rnw ? 3 : 2);
      kind = $urandom_range(0, 5);
      if (kind == 3) nack_s = fs;
      else if (kind == 4) al_s = fs;
      else if (kind == 5) noif_s = fs;
      run(rnw, 7'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
